// File: rtl/int2float_arbiter_pkg.sv
// Shared constants, slot state encoding and the leading-zero helper used by
// the round-robin int-to-float converter block.
package int2float_arbiter_pkg;

  localparam int FP_W = 32;
  localparam int EXP_BIAS = 127;
  localparam logic [FP_W-1:0] ZERO_FLOAT = 32'h0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Leading-zero count of a non-zero word; returns 0 for an all-zero input,
  // which the caller filters out separately.
  function automatic logic [4:0] lzc32(input logic [FP_W-1:0] value);
    logic [4:0] count;
    logic       found;
    count = '0;
    found = 1'b0;
    for (int b = FP_W - 1; b >= 0; b--) begin
      if (!found && value[b]) begin
        count = 5'(FP_W - 1 - b);
        found = 1'b1;
      end
    end
    return count;
  endfunction

endpackage

// File: rtl/int2float.sv
// Combinational integer-to-float converter: the sign bit is copied and the
// whole word is normalised as an unsigned magnitude, truncating low bits.
module int2float
  import int2float_arbiter_pkg::*;
(
  input  logic [FP_W-1:0] value,
  output logic [FP_W-1:0] fp,
  output logic            prec_lost
);

  logic [4:0]      lz;
  logic [7:0]      exponent;
  logic [FP_W-2:0] shifted;
  logic            is_zero;

  assign is_zero  = (value == '0);
  assign lz       = lzc32(value);
  assign exponent = 8'(EXP_BIAS + FP_W - 1) - {3'b000, lz};
  // Leading one moves to bit 31 and is dropped; bits 30..8 are the mantissa.
  assign shifted  = (FP_W-1)'(value << lz);

  assign fp        = is_zero ? ZERO_FLOAT : {value[FP_W-1], exponent, shifted[FP_W-2:8]};
  assign prec_lost = !is_zero && (|shifted[7:0]);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first request at or after ptr, wrapping,
// and nothing when en is low.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  logic [N_REQ-1:0] rot_req;
  logic [N_REQ-1:0] rot_grant;
  logic             found;

  // Rotate so that requester ptr sits at bit 0, then a fixed priority pick.
  assign rot_req = N_REQ'({req, req} >> ptr);

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    rot_grant = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot_req[k]) begin
        rot_grant[k] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign grant = en ? N_REQ'(({rot_grant, rot_grant} << ptr) >> N_REQ) : '0;

endmodule

// File: rtl/int2float_arbiter.sv
// Shares one int2float converter among N_REQ requesters with round-robin
// grants, a single registered response slot and sticky precision-lost flags.
module int2float_arbiter
  import int2float_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [FP_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [FP_W-1:0]       resp_float,
  output logic                  resp_prec_lost,
  output logic [ID_W-1:0]       resp_id,
  output logic [N_REQ-1:0]      sticky_lost,
  input  logic [N_REQ-1:0]      sticky_clr
);

  slot_state_t      state, state_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic             can_load;
  logic             handshake;
  logic [FP_W-1:0]  operand;
  logic [FP_W-1:0]  conv_fp;
  logic             conv_lost;
  logic [N_REQ-1:0] sticky_set;

  assign resp_valid = (state == SLOT_FULL);
  assign handshake  = resp_valid && resp_ready;
  // A full slot can reload in the same cycle its current result leaves.
  assign can_load   = !resp_valid || resp_ready;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (can_load && !rst),
    .grant (grant)
  );

  assign req_ready = grant;
  assign grant_any = |grant;

  always_comb begin
    grant_id = '0;
    operand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_id = grant_id | ID_W'(i);
        operand  = operand | req_data[i*FP_W +: FP_W];
      end
    end
  end

  int2float u_int2float (
    .value     (operand),
    .fp        (conv_fp),
    .prec_lost (conv_lost)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SLOT_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (grant_any) state_next = SLOT_FULL;
      SLOT_FULL:  if (resp_ready && !grant_any) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  // NOTE: the slot payload is reset too, because it drives visible outputs
  // whose reset value software and downstream logic may observe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_float     <= ZERO_FLOAT;
      resp_prec_lost <= 1'b0;
      resp_id        <= '0;
    end else if (grant_any) begin
      resp_float     <= conv_fp;
      resp_prec_lost <= conv_lost;
      resp_id        <= grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Set is applied after the clear so a simultaneous set wins.
  assign sticky_set = handshake ? (N_REQ'(resp_prec_lost) << resp_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_lost <= '0;
    else     sticky_lost <= (sticky_lost & ~sticky_clr) | sticky_set;
  end

endmodule

// File: tb/tb_int2float_arbiter.sv
// Self-checking bench for int2float_arbiter: directed sequences, a vector
// table and randomized traffic compared against a behavioural model.
module tb_int2float_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_float;
  logic          resp_prec_lost;
  logic [IW-1:0] resp_id;
  logic [N-1:0]  sticky_lost;
  logic [N-1:0]  sticky_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  int2float_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_float     (resp_float),
    .resp_prec_lost (resp_prec_lost),
    .resp_id        (resp_id),
    .sticky_lost    (sticky_lost),
    .sticky_clr     (sticky_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference conversion from the arithmetic definition: {float, lost}.
  function automatic logic [32:0] ref_conv(input logic [31:0] x);
    int          p;
    logic [63:0] v;
    logic [22:0] mant;
    logic        lost;
    if (x == 32'h0) return 33'h0;
    p = -1;
    for (int b = 0; b < 32; b++) if (x[b]) p = b;
    v = {32'h0, x};
    if (p >= 23) begin
      mant = 23'((v >> (p - 23)) & 64'h7FFFFF);
      lost = (v & ((64'd1 << (p - 23)) - 64'd1)) != 64'd0;
    end else begin
      mant = 23'((v << (23 - p)) & 64'h7FFFFF);
      lost = 1'b0;
    end
    return {x[31], 8'(127 + p), mant, lost};
  endfunction

  function automatic logic [N-1:0] ref_grant(input logic [N-1:0] v, input int ptr, input bit en);
    int idx;
    if (!en) return '0;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (v[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  // Behavioural model of the slot, pointer and sticky flags.
  logic        m_full = 1'b0;
  logic [31:0] m_float = '0;
  logic        m_lost = 1'b0;
  int          m_id = 0;
  int          m_ptr = 0;
  logic [N-1:0] m_sticky = '0;
  logic [N-1:0] m_last_grant = '0;
  logic [N-1:0] mg;
  logic         mhs;
  logic [32:0]  mc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full = 1'b0; m_float = '0; m_lost = 1'b0; m_id = 0; m_ptr = 0;
      m_sticky = '0; m_last_grant = '0;
    end else begin
      mhs = m_full && resp_ready;
      mg  = ref_grant(req_valid, m_ptr, !m_full || resp_ready);
      m_sticky = m_sticky & ~sticky_clr;
      if (mhs && m_lost) m_sticky[m_id] = 1'b1;
      m_last_grant = mg;
      if (mg != '0) begin
        for (int i = 0; i < N; i++) begin
          if (mg[i]) begin
            mc = ref_conv(req_data[i*32 +: 32]);
            m_float = mc[32:1];
            m_lost  = mc[0];
            m_id    = i;
            m_ptr   = (i + 1) % N;
          end
        end
        m_full = 1'b1;
      end else if (mhs) begin
        m_full = 1'b0;
      end
    end
  end

  typedef struct {
    int          r;
    logic [31:0] data;
    logic [31:0] f;
    logic        lost;
  } vec_t;

  vec_t vecs[8];

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 32'h00000001, 32'h3F800000, 1'b0};
    vecs[1] = '{1, 32'h01000001, 32'h4B800000, 1'b1};
    vecs[2] = '{2, 32'h00000000, 32'h00000000, 1'b0};
    vecs[3] = '{3, 32'h80000000, 32'hCF000000, 1'b0};
    vecs[4] = '{0, 32'h000000FF, 32'h437F0000, 1'b0};
    vecs[5] = '{1, 32'hFFFFFFFF, 32'hCF7FFFFF, 1'b1};
    vecs[6] = '{2, 32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1};
    vecs[7] = '{3, 32'h00000002, 32'h40000000, 1'b0};

    req_valid = '1; req_data = '0; resp_ready = 1'b1; sticky_clr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_valid", 32'(resp_valid), 32'h0);
    check("reset_float", resp_float, 32'h0);
    check("reset_lost_id", {30'h0, resp_prec_lost, 1'b0} | 32'(resp_id), 32'h0);
    check("reset_sticky", 32'(sticky_lost), 32'h0);
    req_valid = '0;
    rst = 1'b0;

    // First conversion: requester 0, value 1.
    req_valid = 4'b0001; req_data[31:0] = 32'h1;
    #2 check("t1_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("t1_valid", 32'(resp_valid), 32'h1);
    check("t1_float", resp_float, 32'h3F800000);
    check("t1_lost", 32'(resp_prec_lost), 32'h0);
    check("t1_id", 32'(resp_id), 32'h0);
    check("t1_ptr", 32'(dut.rr_ptr), 32'h1);
    tick();
    check("t1_drained", 32'(resp_valid), 32'h0);

    // All requesters valid: strict rotation from 0 after reset.
    pulse_reset();
    for (int i = 0; i < N; i++) req_data[i*32 +: 32] = 32'(i + 1);
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      #2 check("rr_grant", 32'(req_ready), 32'(1 << (c % N)));
      tick();
      check("rr_valid", 32'(resp_valid), 32'h1);
      check("rr_id", 32'(resp_id), 32'(c % N));
    end
    req_valid = '0;
    tick();

    // Precision loss sets the sticky bit after handshake; clear removes it.
    req_valid = 4'b0100; req_data[64 +: 32] = 32'h01000001;
    tick();
    req_valid = '0;
    check("st_float", resp_float, 32'h4B800000);
    check("st_lost", 32'(resp_prec_lost), 32'h1);
    check("st_before", 32'(sticky_lost), 32'h0);
    tick();
    check("st_set", 32'(sticky_lost), 32'h4);
    sticky_clr = 4'b0100;
    tick();
    sticky_clr = '0;
    check("st_clr", 32'(sticky_lost), 32'h0);

    // Backpressure: slot full, resp_ready low for 5 cycles.
    resp_ready = 1'b0;
    req_valid = 4'b0001; req_data[31:0] = 32'h5;
    tick();
    req_valid = 4'b0010; req_data[32 +: 32] = 32'h2;
    for (int c = 0; c < 5; c++) begin
      #2 check("bp_no_grant", 32'(req_ready), 32'h0);
      check("bp_float", resp_float, 32'h40A00000);
      check("bp_id_valid", {31'h0, resp_valid} + 32'(resp_id), 32'h1);
      tick();
    end
    resp_ready = 1'b1;
    #2 check("bp_release_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("bp_float2", resp_float, 32'h40000000);
    check("bp_id2", 32'(resp_id), 32'h1);
    tick();

    // Vector table through single requesters.
    foreach (vecs[i]) begin
      req_valid = N'(1) << vecs[i].r;
      req_data[vecs[i].r*32 +: 32] = vecs[i].data;
      tick();
      req_valid = '0;
      check("vec_valid", 32'(resp_valid), 32'h1);
      check("vec_float", resp_float, vecs[i].f);
      check("vec_lost", 32'(resp_prec_lost), 32'(vecs[i].lost));
      check("vec_id", 32'(resp_id), 32'(vecs[i].r));
    end
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      check("rnd_valid", 32'(resp_valid), 32'(m_full));
      if (m_full) begin
        check("rnd_float", resp_float, m_float);
        check("rnd_lost", 32'(resp_prec_lost), 32'(m_lost));
        check("rnd_id", 32'(resp_id), 32'(m_id));
      end
      check("rnd_sticky", 32'(sticky_lost), 32'(m_sticky));
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !m_last_grant[i])) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_data[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFF) : $urandom;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      #2 check("rnd_grant", 32'(req_ready), 32'(ref_grant(req_valid, m_ptr, !m_full || resp_ready)));
      tick();
    end
    req_valid = '0; sticky_clr = '0; resp_ready = 1'b1;
    tick();

    // Asynchronous reset while full with a sticky bit set.
    req_valid = 4'b0100; req_data[64 +: 32] = 32'h01000001;
    tick();
    req_valid = '0;
    tick();
    check("ar_sticky_pre", 32'(sticky_lost[2]), 32'h1);
    resp_ready = 1'b0;
    req_valid = 4'b0001; req_data[31:0] = 32'h7;
    tick();
    req_valid = '0;
    check("ar_full", 32'(resp_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(resp_valid), 32'h0);
    check("ar_sticky", 32'(sticky_lost), 32'h0);
    check("ar_ptr", 32'(dut.rr_ptr), 32'h0);
    check("ar_float", resp_float, 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int2float_arbiter.md
# int2float_arbiter

Shares one combinational `int2float` converter among `N_REQ` independent requesters. Arbitration is round-robin and each requester has a valid/ready handshake. The converted result sits in a single registered response slot, tagged with the requester ID, and the slot honours downstream backpressure. Per-requester sticky precision-lost flags are kept for software readout. The block sits between the integer-producing clients and the FP result bus of the ALU.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_W`, 2: width of the requester ID; must equal ceil(log2(N_REQ)).

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `req_valid`  input  N_REQ  bit i: requester i presents an operand.
- `req_data`  input  32*N_REQ  operand of requester i in bits [32i+31:32i].
- `req_ready`  output  N_REQ  one-hot or zero; bit i means requester i's operand is accepted this cycle.
- `resp_valid`  output  1  response slot is full.
- `resp_ready`  input  1  downstream accepts the response.
- `resp_float`  output  32  converted IEEE-754 single.
- `resp_prec_lost`  output  1  precision-lost flag for this result.
- `resp_id`  output  ID_W  requester that produced this result.
- `sticky_lost`  output  N_REQ  per-requester OR of `resp_prec_lost` over delivered results.
- `sticky_clr`  input  N_REQ  synchronous clear of the matching `sticky_lost` bits.

## Operation
- Slot state machine has two states:
  - EMPTY: `resp_valid`=0.
  - FULL: `resp_valid`=1.
- The slot can load when it is EMPTY, or when it is FULL and `resp_valid & resp_ready` in the same cycle (pass-through).
- Grant rule:
  - When the slot can load and any `req_valid` is set, exactly one `req_ready` bit is asserted.
  - The chosen bit is the first valid requester at or after pointer `rr_ptr`, searching upward and wrapping at N_REQ-1 to 0.
  - Otherwise `req_ready`=0.
- `req_ready` is combinational from `req_valid`, the slot state, `resp_ready` and `rr_ptr`. It must not depend on `req_data`.
- On a grant to requester g:
  - The granted operand is muxed into the shared converter.
  - `{float, precision_lost}` is registered into the slot, with `resp_id`=g.
  - `rr_ptr` is set to (g+1) mod N_REQ.
  - `rr_ptr` holds when there is no grant.
- Transitions:
  - EMPTY to FULL on a grant.
  - FULL to EMPTY on `resp_ready` with no grant.
  - FULL stays FULL either with no `resp_ready`, or with `resp_ready` plus a grant.
- While FULL and `resp_ready`=0, `resp_float`, `resp_prec_lost` and `resp_id` are stable.
- Sticky flags:
  - On a handshake (`resp_valid & resp_ready`), `sticky_lost[resp_id]` |= `resp_prec_lost`.
  - `sticky_clr` bit i clears bit i.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Conversion semantics are those of the shared converter:
  - An all-zero operand gives 0x00000000 with precision_lost=0.
  - Otherwise the exponent is 158 − (leading-zero count), the mantissa is the next 23 bits below the leading one, and precision_lost is the OR of the dropped low bits.
  - The sign is bit 31 copied unchanged; no two's-complement negation is applied.

## Timing
- Reset values:
  - `resp_valid`=0.
  - `resp_float`=0, `resp_prec_lost`=0, `resp_id`=0.
  - `rr_ptr`=0.
  - `sticky_lost`=0.
  - `req_ready` evaluates to 0 while `rst` is high.
- Reset asserted mid-operation discards the slot contents immediately, without waiting for a clock edge.
- Latency: a grant in cycle t gives `resp_valid` with that result in cycle t+1.
- Throughput: one result per cycle while `resp_ready` stays high.
- A `req_valid` that is not granted may stay high indefinitely. Its `req_data` must stay stable until it is granted.
- Fairness: any continuously valid requester is granted within N_REQ grants.

## Structure
- A shared header holds the constants `FP_W`=32, `EXP_BIAS`=127 and `ZERO_FLOAT`=32'h0.
- Round-robin selection lives in one sub-module, `rr_arbiter`:
  - Inputs: request vector, pointer, enable.
  - Output: one-hot grant.
- `int2float_arbiter` instantiates `rr_arbiter` and one `int2float`, and holds the slot register, the pointer and the sticky flags.

## Test plan
- Reset, then requester 0 presents 0x00000001 with `resp_ready`=1. Expect a grant in cycle 0, then `resp_float`=0x3F800000, `resp_prec_lost`=0, `resp_id`=0 in cycle 1. `rr_ptr` becomes 1.
- All 4 requesters hold valid continuously with `resp_ready`=1. Expect grant order 0,1,2,3,0, one per cycle, with `resp_valid` high every cycle from cycle 1.
- Requester 2 presents 0x01000001. Expect `resp_float`=0x4B800000 and `resp_prec_lost`=1; `sticky_lost[2]` goes to 1 after the handshake. Then pulse `sticky_clr[2]` and expect bit 2 back at 0.
- Slot FULL with `resp_ready`=0 for 5 cycles while requester 1 presents 0x00000002. Expect `req_ready`=0 and the response outputs stable. Raise `resp_ready`: the same cycle grants requester 1, and the next cycle shows 0x40000000.
- Operand 0x00000000. Expect 0x00000000 with `resp_prec_lost`=0.
- Assert `rst` asynchronously while FULL. Expect `resp_valid`=0 before the next clock edge, and `rr_ptr` and `sticky_lost` cleared.
